norm_scaler: RTL and testbench

//  Pipelined, frame-gated pixel normaliser; successor to the pass-through normaliser in the crop/filter chain.

---
 rtl/norm_scaler_if.sv | 11 +
 rtl/norm_scaler.sv | 190 +++++++++++++++++++
 tb/tb_norm_scaler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/norm_scaler_if.sv
// Valid/ready/data stream bundle carrying pixel beats into and out of norm_scaler.
interface norm_scaler_if #(
    parameter int DATA_W = 10
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/norm_scaler.sv
// Frame-gated pixel normaliser: serial divide for coef, then a 2-stage scale/saturate pipeline.
// Build option NORM_ROUND_EN selects round-half-up instead of truncation after the multiply.
module norm_scaler #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int LANES           = 1,
    parameter int FRAC_BITS       = 16,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    input  logic                       cf_ap_done,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
    input  logic [CNT_WIDTH-1:0]       frame_beats,
    norm_scaler_if.slave               s_axis,
    norm_scaler_if.master              m_axis
);
    localparam int P   = PIXEL_BIT_WIDTH;
    localparam int F   = FRAC_BITS;
    localparam int CW  = P + F;
    localparam int DW  = LANES * P;
    localparam int PW  = P + CW;
    localparam int DCW = $clog2(CW);
    localparam logic [P-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {IDLE, WAIT_UP, DIV, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [P-1:0]    denom_q, denom_d;
    logic [CNT_WIDTH-1:0] beats_q, beats_d, inCnt_q, inCnt_d, outCnt_q, outCnt_d;
    logic            cfSeen_q, cfSeen_d;
    logic [DCW-1:0]  divCnt_q, divCnt_d;
    logic [P-1:0]    rem_q, rem_d;
    logic [CW-2:0]   quot_q, quot_d;
    logic [CW-1:0]   coef_q, coef_d;
    logic            s1Valid_q, s1Valid_d, outValid_q, outValid_d;
    logic [DW-1:0]   s1Data_q, s1Data_d, outData_q, outData_d;

    logic            pipeEn, sReady, inAccept, outAccept, lastOut, divLast;
    logic            numBit, remGe;
    logic [P:0]      remShift, remSub;
    logic [DW-1:0]   scaled;

    function automatic logic [P-1:0] scalePix(input logic [P-1:0] pix, input logic [CW-1:0] c);
        logic [PW:0] prod;
        prod = (PW+1)'(pix) * (PW+1)'(c);
`ifdef NORM_ROUND_EN
        prod = prod + ((PW+1)'(1) << (F-1));
`endif
        prod = prod >> F;
        return (prod > (PW+1)'(PIX_MAX)) ? PIX_MAX : prod[P-1:0];
    endfunction

    assign pipeEn    = !outValid_q || m_axis.tready;
    assign sReady    = (state_q == RUN) && pipeEn && (inCnt_q < beats_q);
    assign inAccept  = s_axis.tvalid && sReady;
    assign outAccept = outValid_q && m_axis.tready;
    assign lastOut   = outAccept && ((outCnt_q + CNT_WIDTH'(1)) == beats_q);
    assign divLast   = (divCnt_q == DCW'(CW - 1));

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ap_start) state_d = WAIT_UP;
            WAIT_UP: if (cfSeen_q) state_d = DIV;
            DIV:     if (divLast) state_d = RUN;
            RUN:     if ((beats_q == '0) || lastOut) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ap_done       = (state_q == DONE);
        ap_idle       = (state_q == IDLE);
        ap_ready      = (state_q == IDLE);
        s_axis.tready = sReady;
        m_axis.tvalid = outValid_q;
        m_axis.tdata  = outData_q;
    end

    // Numerator (2^P-1)<<F is P ones then F zeros, so its bits fall out of the divide counter.
    always_comb begin
        numBit   = (divCnt_q < DCW'(P));
        remShift = {rem_q, numBit};
        remGe    = (remShift >= {1'b0, denom_q});
        remSub   = remShift - {1'b0, denom_q};
        scaled   = '0;
        for (int i = 0; i < LANES; i++) begin
            scaled[i*P +: P] = scalePix(s1Data_q[i*P +: P], coef_q);
        end

        denom_d    = denom_q;
        beats_d    = beats_q;
        inCnt_d    = inCnt_q;
        outCnt_d   = outCnt_q;
        cfSeen_d   = cfSeen_q;
        divCnt_d   = divCnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        coef_d     = coef_q;
        s1Valid_d  = 1'b0;
        s1Data_d   = s1Data_q;
        outValid_d = 1'b0;
        outData_d  = outData_q;

        if (state_q == IDLE) begin
            if (ap_start) begin
                denom_d  = norm_denominator;
                beats_d  = frame_beats;
                cfSeen_d = cf_ap_done;
                inCnt_d  = '0;
                outCnt_d = '0;
            end
        end else begin
            cfSeen_d = cfSeen_q | cf_ap_done;
        end

        case (state_q)
            WAIT_UP: begin
                divCnt_d = '0;
                rem_d    = '0;
                quot_d   = '0;
            end
            DIV: begin
                divCnt_d = divCnt_q + DCW'(1);
                rem_d    = remGe ? remSub[P-1:0] : remShift[P-1:0];
                quot_d   = {quot_q[CW-3:0], remGe};
                if (divLast) coef_d = (denom_q == '0) ? '1 : {quot_q, remGe};
            end
            RUN: begin
                s1Valid_d  = s1Valid_q;
                outValid_d = outValid_q;
                if (pipeEn) begin
                    s1Valid_d  = inAccept;
                    s1Data_d   = s_axis.tdata;
                    outValid_d = s1Valid_q;
                    outData_d  = scaled;
                end
                if (inAccept)  inCnt_d  = inCnt_q + CNT_WIDTH'(1);
                if (outAccept) outCnt_d = outCnt_q + CNT_WIDTH'(1);
                if (lastOut) begin
                    s1Valid_d  = 1'b0;
                    outValid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            denom_q    <= '0;
            beats_q    <= '0;
            inCnt_q    <= '0;
            outCnt_q   <= '0;
            cfSeen_q   <= 1'b0;
            divCnt_q   <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            coef_q     <= '0;
            s1Valid_q  <= 1'b0;
            s1Data_q   <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            denom_q    <= denom_d;
            beats_q    <= beats_d;
            inCnt_q    <= inCnt_d;
            outCnt_q   <= outCnt_d;
            cfSeen_q   <= cfSeen_d;
            divCnt_q   <= divCnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            coef_q     <= coef_d;
            s1Valid_q  <= s1Valid_d;
            s1Data_q   <= s1Data_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end
endmodule

// File: tb/tb_norm_scaler.sv
// Randomised frame bench for norm_scaler (4 lanes) scored against an arithmetic model of the scaling rule.
module tb_norm_scaler;
    localparam int P     = 10;
    localparam int F     = 16;
    localparam int LANES = 4;
    localparam int CW    = P + F;
    localparam int CNTW  = 32;
    localparam int DW    = LANES * P;

    logic            clk = 1'b0;
    logic            rstN;
    logic            apStart, cfIn;
    logic            ap_done, ap_idle, ap_ready;
    logic [P-1:0]    denomIn;
    logic [CNTW-1:0] beatsIn;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] inQ[$];
    logic [DW-1:0] expQ[$];

    norm_scaler_if #(.DATA_W(DW)) sIf ();
    norm_scaler_if #(.DATA_W(DW)) mIf ();

    norm_scaler #(
        .PIXEL_BIT_WIDTH(P), .LANES(LANES), .FRAC_BITS(F), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .s_axis_resetn(rstN), .ap_start(apStart), .cf_ap_done(cfIn),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .norm_denominator(denomIn), .frame_beats(beatsIn),
        .s_axis(sIf), .m_axis(mIf)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Scale rule evaluated with plain integer arithmetic on every lane.
    function automatic logic [DW-1:0] modelBeat(input logic [DW-1:0] d, input logic [P-1:0] denom);
        longint unsigned coef, prod, res, pixMax;
        logic [DW-1:0] r;
        pixMax = (64'd1 << P) - 1;
        coef = (denom == 0) ? ((64'd1 << CW) - 1) : ((pixMax << F) / longint'(denom));
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = longint'(d[i*P +: P]) * coef;
`ifdef NORM_ROUND_EN
            prod = prod + (64'd1 << (F - 1));
`endif
            res = prod >> F;
            if (res > pixMax) res = pixMax;
            r[i*P +: P] = res[P-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] randBeat();
        return DW'({$urandom, $urandom});
    endfunction

    function automatic logic [DW-1:0] lane0Beat(input logic [P-1:0] p);
        logic [DW-1:0] b;
        b = randBeat();
        b[P-1:0] = p;
        return b;
    endfunction

    task automatic applyStimulus(input logic [P-1:0] denom, input int beats, input int validPct,
                                 input int readyPct, input int cfDelay, input int resetAt);
        int sent, got, firstReady, firstValid, firstOut, lastOut, doneCyc, doneCnt;
        bit timedOut;
        sent = 0; got = 0; doneCnt = 0; timedOut = 1'b1;
        firstReady = -1; firstValid = -1; firstOut = -1; lastOut = -1; doneCyc = -1;
        expQ.delete();
        checkOutput("idleBeforeStart", ap_idle, 1);
        checkOutput("readyBeforeStart", ap_ready, 1);
        cfIn = 1'b1;
        @(posedge clk); #1;
        apStart = 1'b1; denomIn = denom; beatsIn = CNTW'(beats); cfIn = (cfDelay == 0);
        @(posedge clk); #1;
        apStart = 1'b0; cfIn = 1'b0; denomIn = P'($urandom); beatsIn = $urandom;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            cfIn        = (cyc == cfDelay);
            sIf.tvalid  = (sent < inQ.size()) && ($urandom_range(0, 99) < validPct);
            sIf.tdata   = (sent < inQ.size()) ? inQ[sent] : randBeat();
            mIf.tready  = ($urandom_range(0, 99) < readyPct);
            #1;
            if (sIf.tready && firstReady < 0) firstReady = cyc;
            if (mIf.tvalid && firstValid < 0) firstValid = cyc;
            if (sIf.tvalid && sIf.tready) begin
                expQ.push_back(modelBeat(inQ[sent], denom));
                sent++;
            end
            if (mIf.tvalid && mIf.tready) begin
                if (expQ.size() == 0) checkOutput("unexpectedBeat", 1, 0);
                else checkOutput($sformatf("beat%0d", got), mIf.tdata, expQ.pop_front());
                if (firstOut < 0) firstOut = cyc;
                lastOut = cyc;
                got++;
            end
            if (ap_done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            @(posedge clk); #1;
            if (doneCyc >= 0 || (resetAt >= 0 && got >= resetAt)) begin
                timedOut = 1'b0;
                break;
            end
        end
        sIf.tvalid = 1'b0;
        cfIn = 1'b0;
        checkOutput("frameTimeout", timedOut, 0);
        if (resetAt >= 0) begin
            rstN = 1'b0;
            #1;
            checkOutput("rstIdle", ap_idle, 1);
            checkOutput("rstOutValid", mIf.tvalid, 0);
            checkOutput("rstInReady", sIf.tready, 0);
            checkOutput("rstNoDone", doneCnt + int'(ap_done), 0);
            repeat (2) @(posedge clk);
            #1 rstN = 1'b1;
            @(posedge clk); #1;
            checkOutput("idleAfterReset", ap_idle, 1);
            return;
        end
        checkOutput("firstReadyCycle", firstReady, (beats > 0) ? 28 + cfDelay : -1);
        checkOutput("beatsAccepted", sent, beats);
        checkOutput("beatsOut", got, beats);
        checkOutput("leftover", expQ.size(), 0);
        checkOutput("doneCount", doneCnt, 1);
        checkOutput("doneCycle", doneCyc, (beats > 0) ? lastOut + 1 : 29 + cfDelay);
        if (validPct == 100 && beats > 0) checkOutput("latency", firstValid, firstReady + 2);
        if (validPct == 100 && readyPct == 100 && beats > 0)
            checkOutput("throughput", lastOut - firstOut, beats - 1);
        checkOutput("doneCleared", ap_done, 0);
        checkOutput("idleAfter", ap_idle, 1);
        checkOutput("outValidAfter", mIf.tvalid, 0);
    endtask

    initial begin
        rstN = 1'b0; apStart = 1'b0; cfIn = 1'b0; denomIn = '0; beatsIn = '0;
        sIf.tvalid = 1'b0; sIf.tdata = '0; mIf.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstDone", ap_done, 0);
        checkOutput("rstIdleInit", ap_idle, 1);
        checkOutput("rstReadyInit", ap_ready, 1);
        checkOutput("rstSReady", sIf.tready, 0);
        checkOutput("rstMValid", mIf.tvalid, 0);
        checkOutput("rstMData", mIf.tdata, 0);
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] unity coefficient");
        inQ.delete();
        inQ.push_back(lane0Beat(10'd0));   inQ.push_back(lane0Beat(10'd1));
        inQ.push_back(lane0Beat(10'd512)); inQ.push_back(lane0Beat(10'd1023));
        applyStimulus(10'd1023, 4, 100, 100, 0, -1);

        $display("[TB] half-range denominator");
        inQ.delete();
        inQ.push_back(lane0Beat(10'd256)); inQ.push_back(lane0Beat(10'd1023));
        applyStimulus(10'd512, 2, 100, 100, 0, -1);

        $display("[TB] zero denominator");
        inQ.delete();
        inQ.push_back(lane0Beat(10'd0)); inQ.push_back(lane0Beat(10'd5));
        applyStimulus(10'd0, 2, 100, 100, 0, -1);

        $display("[TB] late upstream done");
        inQ.delete();
        for (int i = 0; i < 8; i++) inQ.push_back(randBeat());
        applyStimulus(P'($urandom_range(1, 1023)), 8, 100, 100, 5, -1);

        $display("[TB] random backpressure");
        inQ.delete();
        for (int i = 0; i < 64; i++) inQ.push_back(randBeat());
        applyStimulus(P'($urandom_range(1, 1023)), 64, 100, 50, 0, -1);

        $display("[TB] full throughput");
        inQ.delete();
        for (int i = 0; i < 64; i++) inQ.push_back(randBeat());
        applyStimulus(P'($urandom_range(1, 1023)), 64, 100, 100, 0, -1);

        $display("[TB] empty frame");
        inQ.delete();
        applyStimulus(P'($urandom_range(1, 1023)), 0, 100, 100, 0, -1);

        $display("[TB] reset mid-frame");
        inQ.delete();
        for (int i = 0; i < 64; i++) inQ.push_back(randBeat());
        applyStimulus(P'($urandom_range(1, 1023)), 64, 100, 70, 0, 10);

        $display("[TB] frame after reset");
        inQ.delete();
        for (int i = 0; i < 20; i++) inQ.push_back(randBeat());
        applyStimulus(P'($urandom_range(1, 1023)), 20, 60, 60, 0, -1);

        $display("[TB] surplus input beats");
        inQ.delete();
        for (int i = 0; i < 11; i++) inQ.push_back(randBeat());
        applyStimulus(P'($urandom_range(1, 1023)), 6, 100, 100, 0, -1);

        $display("[TB] random frames");
        for (int f = 0; f < 3; f++) begin
            int nb;
            nb = $urandom_range(1, 24);
            inQ.delete();
            for (int i = 0; i < nb; i++) inQ.push_back(randBeat());
            applyStimulus(P'($urandom_range(0, 40)), nb, 80, 75, $urandom_range(0, 3), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
